my_pe_controller: RTL and testbench
===================================

// Module: my_pe_controller
// PURPOSE
//   Sequencer that sits directly upstream of one my_pe instance. It fetches
//   operand vectors from a global BRAM, loads vector B into the PE's local RAM,
//   clears the PE accumulator, and issues one multiply-accumulate per element.
//   It returns the final dot product A.B (IEEE-754 single precision) with a done pulse.
// PARAMETERS
//   VECTOR_SIZE  32  data width; must match my_pe
//   L_RAM_SIZE   4   PE RAM address width; vector length N = 2**L_RAM_SIZE
//   TIMEOUT      63  max cycles waiting for pe_dvalid per element before abort
// PORTS
//   aclk        in   1             clock
//   aresetn     in   1             synchronous, active-low reset
//   start       in   1             start a dot product (sampled in IDLE only)
//   done        out  1             1-cycle pulse at end of run
//   err         out  1             set with done on timeout; cleared on next start
//   result      out  VECTOR_SIZE   final PE accumulator value, held until next done
//   rdaddr      out  L_RAM_SIZE+1  global BRAM read address
//   rddata      in   VECTOR_SIZE   global BRAM data, valid 1 cycle after rdaddr
//   pe_aresetn  out  1             PE reset (active-low, registered)
//   pe_ain      out  VECTOR_SIZE   PE port A operand
//   pe_din      out  VECTOR_SIZE   PE RAM write data
//   pe_addr     out  L_RAM_SIZE    PE RAM address
//   pe_we       out  1             PE RAM write enable
//   pe_valid    out  1             PE operand valid
//   pe_dvalid   in   1             PE result valid
//   pe_dout     in   VECTOR_SIZE   PE result
// BEHAVIOUR
// - Reset: state=IDLE. All outputs are 0, including pe_aresetn=0 (PE held in reset).
// - Global memory map: words 0..N-1 = vector B; words N..2N-1 = vector A.
// - States: IDLE -> LOAD -> CLR -> RD -> ISSUE -> WAIT -> (RD | DONE) -> IDLE.
// - IDLE: pe_aresetn=1. When start=1: clear err, go to LOAD. start is ignored in all other states.
// - LOAD: rdaddr steps 0..N-1, one word per cycle. One cycle later:
//   pe_we=1, pe_addr=i, pe_din=rddata(i). Exactly N writes, in order.
//   LOAD takes N+1 cycles.
// - CLR: pe_aresetn=0 for exactly 2 cycles (FP core minimum), which zeroes
//   the PE's feedback register. pe_we=0.
// - RD (element i): rdaddr=N+i, pe_addr=i, pe_we=0. Lasts 1 cycle. This covers
//   the registered read latency of both the PE RAM and the global BRAM.
// - ISSUE: pe_valid=1 for exactly 1 cycle, pe_ain=rddata (A[i]), pe_addr=i.
//   The wait counter is cleared.
// - WAIT: pe_valid=0. On pe_dvalid=1: if i==N-1, latch result=pe_dout and go
//   to DONE; otherwise i++ and go to RD.
//   Only one element is in flight at a time, because the PE feedback register
//   updates only on dvalid.
//   If the counter reaches TIMEOUT with no dvalid: err=1, go to DONE, result unchanged.
// - pe_dvalid outside WAIT is ignored.
// - DONE: done=1 for 1 cycle, then IDLE. pe_aresetn stays 1, so the PE result
//   remains observable.
// - Index i is L_RAM_SIZE bits and does not wrap within a run. rdaddr is the
//   concatenation {phase, i}: phase 0 = B, phase 1 = A.
// - Reset mid-run: back to IDLE in the same cycle. Partial results are discarded,
//   the PE is held in reset, and no done pulse is produced.
// - Run length without timeout: (N+1) + 2 + N*(2 + L_fp) + 1 cycles,
//   where L_fp = PE FP-core latency.
// TESTING
// 1. B=1.0 (0x3F800000) x16, A=1.0..16.0, start
//    -> one done pulse, result=136.0 (0x43080000), err=0.
// 2. Back-to-back run: B=0.5 x16, A=2.0 x16
//    -> result=16.0 (0x41800000), not 152.0, proving the CLR stage works.
// 3. start pulsed during LOAD and WAIT -> ignored; exactly one done per accepted start.
// 4. PE model never asserts dvalid -> err=1 and done after TIMEOUT+1 WAIT cycles;
//    result keeps its previous value.
// 5. aresetn low for 1 cycle mid-WAIT -> all outputs 0 the next cycle, no done;
//    a new start then gives the correct result.
// 6. Protocol monitor: exactly N pe_we pulses at addresses 0..N-1; exactly N
//    single-cycle pe_valid pulses, each preceded by a RD cycle with matching pe_addr.

Source files
------------

// File: rtl/my_pe_controller.sv
// Sequencer in front of one my_pe: loads vector B into the PE RAM, clears the PE
// accumulator, then issues one MAC per element of A and returns the dot product.
module my_pe_controller #(
  parameter int unsigned VECTOR_SIZE = 32,
  parameter int unsigned L_RAM_SIZE  = 4,
  parameter int unsigned TIMEOUT     = 63
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   start,
  output logic                   done,
  output logic                   err,
  output logic [VECTOR_SIZE-1:0] result,
  output logic [L_RAM_SIZE:0]    rdaddr,
  input  logic [VECTOR_SIZE-1:0] rddata,
  output logic                   pe_aresetn,
  output logic [VECTOR_SIZE-1:0] pe_ain,
  output logic [VECTOR_SIZE-1:0] pe_din,
  output logic [L_RAM_SIZE-1:0]  pe_addr,
  output logic                   pe_we,
  output logic                   pe_valid,
  input  logic                   pe_dvalid,
  input  logic [VECTOR_SIZE-1:0] pe_dout
);

  localparam int unsigned N  = 2 ** L_RAM_SIZE;
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned CW = (TW > L_RAM_SIZE + 1) ? TW : L_RAM_SIZE + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLR,
    S_RD,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [L_RAM_SIZE-1:0]  idx_q, idx_d;
  logic                   err_q, err_d;
  logic [VECTOR_SIZE-1:0] result_q, result_d;
  logic                   pe_rstn_q, pe_rstn_d;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      result_q  <= '0;
      pe_rstn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      result_q  <= result_d;
      pe_rstn_q <= pe_rstn_d;
    end
  end

  // cnt_q is shared: LOAD word counter, CLR cycle counter, WAIT timeout counter
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    err_d    = err_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (cnt_q == CW'(N)) begin
          cnt_d   = '0;
          state_d = S_CLR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CLR: begin
        if (cnt_q == CW'(1)) begin
          idx_d   = '0;
          state_d = S_RD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RD: state_d = S_ISSUE;
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (pe_dvalid) begin
          if (&idx_q) begin
            result_d = pe_dout;
            state_d  = S_DONE;
          end else begin
            idx_d   = idx_q + L_RAM_SIZE'(1);
            state_d = S_RD;
          end
        end else if (cnt_q == CW'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    pe_rstn_d = (state_d != S_CLR);
  end

  always_comb begin
    done       = (state_q == S_DONE);
    err        = err_q;
    result     = result_q;
    pe_aresetn = pe_rstn_q;
    rdaddr     = '0;
    pe_addr    = '0;
    pe_we      = 1'b0;
    pe_valid   = 1'b0;
    pe_din     = '0;
    pe_ain     = '0;
    unique case (state_q)
      S_LOAD: begin
        // write trails the BRAM read by one cycle, so word k lands on count k+1
        rdaddr = {1'b0, cnt_q[L_RAM_SIZE-1:0]};
        if (cnt_q != '0) begin
          pe_we   = 1'b1;
          pe_addr = cnt_q[L_RAM_SIZE-1:0] - L_RAM_SIZE'(1);
          pe_din  = rddata;
        end
      end
      S_RD, S_WAIT: begin
        rdaddr  = {1'b1, idx_q};
        pe_addr = idx_q;
      end
      S_ISSUE: begin
        rdaddr   = {1'b1, idx_q};
        pe_addr  = idx_q;
        pe_valid = 1'b1;
        pe_ain   = rddata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_my_pe_controller.sv
// Bench for my_pe_controller: global BRAM and behavioural FP PE models, a scoreboard
// of expected result/err/run length popped on each done, and a protocol monitor.
`timescale 1ns/1ps
module tb_my_pe_controller;

  localparam int VS     = 32;
  localparam int LR     = 4;
  localparam int TO     = 63;
  localparam int N      = 16;
  localparam int L_FP   = 5;
  localparam int LEN_OK = (N + 1) + 2 + N * (2 + L_FP) + 1;
  localparam int LEN_TO = (N + 1) + 2 + 2 + (TO + 1) + 1;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic          done, err;
  logic [VS-1:0] result;
  logic [LR:0]   rdaddr;
  logic [VS-1:0] rddata;
  logic          pe_aresetn;
  logic [VS-1:0] pe_ain, pe_din;
  logic [LR-1:0] pe_addr;
  logic          pe_we, pe_valid, pe_dvalid;
  logic [VS-1:0] pe_dout;

  my_pe_controller #(.VECTOR_SIZE(VS), .L_RAM_SIZE(LR), .TIMEOUT(TO)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .done(done), .err(err),
    .result(result), .rdaddr(rdaddr), .rddata(rddata), .pe_aresetn(pe_aresetn),
    .pe_ain(pe_ain), .pe_din(pe_din), .pe_addr(pe_addr), .pe_we(pe_we),
    .pe_valid(pe_valid), .pe_dvalid(pe_dvalid), .pe_dout(pe_dout)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_done = 0;
  int start_cyc = 0;
  int we_cnt = 0;
  int valid_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic real sp2real(input logic [31:0] b);
    logic [10:0] e;
    logic [63:0] d;
    if (b[30:0] == 31'd0) return 0.0;
    e = {3'b000, b[30:23]} + 11'd896;
    d = {b[31], e, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  always @(posedge aclk) cyc <= cyc + 1;

  // global BRAM: one-cycle registered read
  logic [31:0] gmem [0:2*N-1];
  always @(posedge aclk) rddata <= gmem[rdaddr];

  // PE model: RAM survives pe_aresetn, accumulator is cleared by it
  logic [31:0] pe_ram [0:N-1];
  real acc = 0.0;
  real pend = 0.0;
  int  cd = 0;
  bit  mute = 1'b0;

  always @(posedge aclk) begin
    if (pe_we === 1'b1) pe_ram[pe_addr] <= pe_din;
    if (pe_aresetn === 1'b0) begin
      acc <= 0.0;
      cd  <= 0;
    end else if (pe_valid === 1'b1) begin
      cd   <= L_FP;
      pend <= acc + sp2real(pe_ain) * sp2real(pe_ram[pe_addr]);
    end else if (cd > 0) begin
      cd <= cd - 1;
      if (cd == 1 && !mute) acc <= pend;
    end
  end

  always_comb begin
    pe_dvalid = (cd == 1) && !mute;
    pe_dout   = pe_dvalid ? real2sp(pend) : real2sp(acc);
  end

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          len;
  } exp_t;
  exp_t sb[$];

  logic        prev_done = 1'b0;
  logic        prev_valid = 1'b0;
  logic [LR:0] prev_rdaddr = '0;
  logic [LR-1:0] prev_addr = '0;

  always @(negedge aclk) begin
    exp_t e;
    if (aresetn && pe_we === 1'b1) begin
      check("we_addr", 32'(pe_addr), 32'(we_cnt));
      check("we_data", pe_din, gmem[pe_addr]);
      we_cnt++;
    end
    if (aresetn && pe_valid === 1'b1) begin
      check("valid_single", 32'(prev_valid), 32'd0);
      check("rd_before_issue", 32'({prev_rdaddr, prev_addr}), 32'({1'b1, pe_addr, pe_addr}));
      check("issue_idx", 32'(pe_addr), 32'(valid_cnt));
      check("issue_ain", pe_ain, gmem[N + int'(pe_addr)]);
      valid_cnt++;
    end
    if (done === 1'b1) begin
      check("done_single", 32'(prev_done), 32'd0);
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("err", 32'(err), 32'(e.err));
        check("run_len", 32'(cyc - start_cyc + 1), 32'(e.len));
        if (!e.err) begin
          check("we_count", 32'(we_cnt), 32'(N));
          check("valid_count", 32'(valid_cnt), 32'(N));
        end else begin
          check("valid_count_to", 32'(valid_cnt), 32'd1);
        end
      end
      n_done++;
    end
    prev_done   = (done === 1'b1);
    prev_valid  = (pe_valid === 1'b1);
    prev_rdaddr = rdaddr;
    prev_addr   = pe_addr;
  end

  task automatic kick(input logic [31:0] res, input logic e_err, input int len);
    exp_t x;
    @(negedge aclk);
    start = 1'b1;
    x.res = res;
    x.err = e_err;
    x.len = len;
    sb.push_back(x);
    @(negedge aclk);
    start     = 1'b0;
    start_cyc = cyc;
    we_cnt    = 0;
    valid_cnt = 0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (n_done < target && k < budget) begin
      @(negedge aclk);
      k++;
    end
    if (n_done < target) check("done_timeout", 32'(n_done), 32'(target));
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (pe_valid !== 1'b1 && k < budget) begin
      @(negedge aclk);
      k++;
    end
    if (pe_valid !== 1'b1) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_zero(input string p);
    check({p, "_done"}, 32'(done), 32'd0);
    check({p, "_err"}, 32'(err), 32'd0);
    check({p, "_result"}, result, 32'd0);
    check({p, "_rdaddr"}, 32'(rdaddr), 32'd0);
    check({p, "_pe_aresetn"}, 32'(pe_aresetn), 32'd0);
    check({p, "_pe_ain"}, pe_ain, 32'd0);
    check({p, "_pe_din"}, pe_din, 32'd0);
    check({p, "_pe_addr"}, 32'(pe_addr), 32'd0);
    check({p, "_pe_we"}, 32'(pe_we), 32'd0);
    check({p, "_pe_valid"}, 32'(pe_valid), 32'd0);
  endtask

  initial begin
    real sum;
    logic [31:0] last_res;

    for (int i = 0; i < N; i++) begin
      gmem[i]     = 32'h3F80_0000;
      gmem[N + i] = real2sp(real'(i + 1));
    end
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    check_zero("rst");
    aresetn = 1'b1;

    // 1.0 x16 dot 1..16
    kick(32'h4308_0000, 1'b0, LEN_OK);
    wait_done(1, 400);

    // back-to-back: accumulator must have been cleared
    for (int i = 0; i < N; i++) begin
      gmem[i]     = 32'h3F00_0000;
      gmem[N + i] = 32'h4000_0000;
    end
    kick(32'h4180_0000, 1'b0, LEN_OK);
    wait_done(2, 400);

    // random small integers; stray start pulses during LOAD and WAIT
    sum = 0.0;
    for (int i = 0; i < N; i++) begin
      int b, a;
      b = int'($urandom_range(0, 7));
      a = int'($urandom_range(0, 9));
      gmem[i]     = real2sp(real'(b));
      gmem[N + i] = real2sp(real'(a));
      sum += real'(a * b);
    end
    last_res = real2sp(sum);
    kick(last_res, 1'b0, LEN_OK);
    repeat (3) @(negedge aclk);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    wait_valid(100);
    @(negedge aclk);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    wait_done(3, 400);
    repeat (150) @(negedge aclk);
    check("extra_done", 32'(n_done), 32'd3);

    // PE never answers: timeout keeps the previous result
    mute = 1'b1;
    kick(last_res, 1'b1, LEN_TO);
    wait_done(4, 300);
    mute = 1'b0;

    // next start clears err
    kick(last_res, 1'b0, LEN_OK);
    check("err_clear", 32'(err), 32'd0);
    wait_done(5, 400);

    // reset pulse mid-WAIT: outputs zero, no done, then a clean run
    for (int i = 0; i < N; i++) begin
      gmem[i]     = 32'h3F80_0000;
      gmem[N + i] = real2sp(real'(i + 1));
    end
    kick(32'h4308_0000, 1'b0, LEN_OK);
    wait_valid(100);
    repeat (2) @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    check_zero("midrst");
    aresetn = 1'b1;
    void'(sb.pop_back());
    repeat (20) @(negedge aclk);
    check("no_done_after_rst", 32'(n_done), 32'd5);
    kick(32'h4308_0000, 1'b0, LEN_OK);
    wait_done(6, 400);
    repeat (5) @(negedge aclk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
